// File: rtl/seletor_zona_matriz.sv
// Cursor-to-zone selector for the LED-matrix demux: MOVE / SCAN / LOCKED FSM over a zone grid.
// Define SELETOR_WRAP_EN for wrapping moves; default saturates. "release" is reserved, so the unlock pulse is release_lock.
module seletor_zona_matriz #(
    parameter int COL_W   = 3,
    parameter int ROW_W   = 3,
    parameter int ZW_LOG2 = 1,
    parameter int ZH_LOG2 = 1,
    parameter int DWELL   = 4,
    localparam int SEL_W  = (COL_W - ZW_LOG2) + (ROW_W - ZH_LOG2)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mv_up,
    input  logic             mv_down,
    input  logic             mv_left,
    input  logic             mv_right,
    input  logic             scan_start,
    input  logic             scan_stop,
    input  logic             confirm,
    input  logic             release_lock,
    output logic [COL_W-1:0] mdc,
    output logic [ROW_W-1:0] mdl,
    output logic [SEL_W-1:0] dmx_sel,
    output logic             sel_changed,
    output logic             locked
);

    localparam int ZX_W  = COL_W - ZW_LOG2;
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [31:0] COL_MAX = (32'd1 << COL_W) - 32'd1;
    localparam logic [31:0] ROW_MAX = (32'd1 << ROW_W) - 32'd1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    typedef enum logic [1:0] {
        MOVE   = 2'd0,
        SCAN   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [COL_W-1:0] mdc_n;
    logic [ROW_W-1:0] mdl_n;
    logic [SEL_W-1:0] sel_n;
    logic [SEL_W-1:0] sel_scan;

    // One-axis cursor step; opposing pulses cancel.
    function automatic logic [31:0] step(input logic [31:0] v, input logic [31:0] vmax,
                                         input logic inc, input logic dec);
        step = v;
        if (inc && !dec) begin
`ifdef SELETOR_WRAP_EN
            step = (v == vmax) ? 32'd0 : v + 32'd1;
`else
            step = (v == vmax) ? v : v + 32'd1;
`endif
        end else if (dec && !inc) begin
`ifdef SELETOR_WRAP_EN
            step = (v == 32'd0) ? vmax : v - 32'd1;
`else
            step = (v == 32'd0) ? v : v - 32'd1;
`endif
        end
    endfunction

    // Zone index with the row part in the MSBs.
    function automatic logic [SEL_W-1:0] zone_of(input logic [COL_W-1:0] c, input logic [ROW_W-1:0] r);
        logic [31:0] zx;
        logic [31:0] zy;
        zx = 32'(c) >> ZW_LOG2;
        zy = 32'(r) >> ZH_LOG2;
        zone_of = SEL_W'((zy << ZX_W) | zx);
    endfunction

    function automatic logic [COL_W-1:0] zone_col(input logic [SEL_W-1:0] s);
        logic [31:0] s32;
        s32 = 32'(s);
        zone_col = COL_W'((s32 & ((32'd1 << ZX_W) - 32'd1)) << ZW_LOG2);
    endfunction

    function automatic logic [ROW_W-1:0] zone_row(input logic [SEL_W-1:0] s);
        logic [31:0] s32;
        s32 = 32'(s);
        zone_row = ROW_W'((s32 >> ZX_W) << ZH_LOG2);
    endfunction

    // Incrementing the packed index advances zx with carry into zy and wraps after the last zone.
    assign sel_scan = dmx_sel + 1'b1;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        mdc_n   = mdc;
        mdl_n   = mdl;
        unique case (state)
            MOVE: begin
                if (confirm) begin
                    state_n = LOCKED;
                end else if (scan_start) begin
                    state_n = SCAN;
                    cnt_n   = '0;
                    mdc_n   = zone_col(dmx_sel);
                    mdl_n   = zone_row(dmx_sel);
                end else begin
                    mdc_n = COL_W'(step(32'(mdc), COL_MAX, mv_right, mv_left));
                    mdl_n = ROW_W'(step(32'(mdl), ROW_MAX, mv_down, mv_up));
                end
            end
            SCAN: begin
                if (confirm) begin
                    state_n = LOCKED;
                end else if (scan_stop) begin
                    state_n = MOVE;
                end else if (cnt == CNT_LAST) begin
                    cnt_n = '0;
                    mdc_n = zone_col(sel_scan);
                    mdl_n = zone_row(sel_scan);
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            LOCKED: begin
                if (release_lock) begin
                    state_n = MOVE;
                end
            end
            default: begin
                state_n = MOVE;
            end
        endcase
        sel_n = zone_of(mdc_n, mdl_n);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= MOVE;
            cnt         <= '0;
            mdc         <= '0;
            mdl         <= '0;
            dmx_sel     <= '0;
            sel_changed <= 1'b0;
            locked      <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            mdc         <= mdc_n;
            mdl         <= mdl_n;
            dmx_sel     <= sel_n;
            sel_changed <= (sel_n != dmx_sel);
            locked      <= (state_n == LOCKED);
        end
    end

endmodule

// File: tb/tb_seletor_zona_matriz.sv
// Bench for seletor_zona_matriz: directed test-plan steps plus random pulses against a cursor/zone model.
module tb_seletor_zona_matriz;

    localparam int NC = 8, NR = 8, ZWC = 2, ZHR = 2, ZXN = 4, ZONES = 16, D = 4;
    localparam logic [7:0] U = 8'h01, DN = 8'h02, L = 8'h04, R = 8'h08;
    localparam logic [7:0] ST = 8'h10, SP = 8'h20, CF = 8'h40, RL = 8'h80;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic mv_up = 1'b0, mv_down = 1'b0, mv_left = 1'b0, mv_right = 1'b0;
    logic scan_start = 1'b0, scan_stop = 1'b0, confirm = 1'b0, release_lock = 1'b0;
    logic [2:0] mdc;
    logic [2:0] mdl;
    logic [3:0] dmx_sel;
    logic sel_changed;
    logic locked;

    int checks = 0;
    int failures = 0;

    // model state: mode 0 = move, 1 = scan, 2 = locked
    int m_col, m_row, m_mode, m_cnt, m_chg;

    seletor_zona_matriz dut (
        .clk(clk), .reset(reset),
        .mv_up(mv_up), .mv_down(mv_down), .mv_left(mv_left), .mv_right(mv_right),
        .scan_start(scan_start), .scan_stop(scan_stop),
        .confirm(confirm), .release_lock(release_lock),
        .mdc(mdc), .mdl(mdl), .dmx_sel(dmx_sel),
        .sel_changed(sel_changed), .locked(locked)
    );

    always #5 clk = ~clk;

    function automatic int m_zone();
        return (m_row / ZHR) * ZXN + (m_col / ZWC);
    endfunction

    function automatic int axis(input int v, input int d, input int n);
        int x;
        x = v + d;
`ifdef SELETOR_WRAP_EN
        return (x + n) % n;
`else
        if (x < 0) return 0;
        if (x > n - 1) return n - 1;
        return x;
`endif
    endfunction

    task automatic m_reset();
        m_col = 0; m_row = 0; m_mode = 0; m_cnt = 0; m_chg = 0;
    endtask

    task automatic m_update(input logic [7:0] p);
        int z0, z;
        z0 = m_zone();
        case (m_mode)
            0: begin
                if (p & CF) m_mode = 2;
                else if (p & ST) begin
                    m_mode = 1; m_cnt = 0;
                    m_col = (m_col / ZWC) * ZWC;
                    m_row = (m_row / ZHR) * ZHR;
                end else begin
                    m_col = axis(m_col, int'(p[3]) - int'(p[2]), NC);
                    m_row = axis(m_row, int'(p[1]) - int'(p[0]), NR);
                end
            end
            1: begin
                if (p & CF) m_mode = 2;
                else if (p & SP) m_mode = 0;
                else if (m_cnt == D - 1) begin
                    m_cnt = 0;
                    z = (z0 + 1) % ZONES;
                    m_col = (z % ZXN) * ZWC;
                    m_row = (z / ZXN) * ZHR;
                end else m_cnt++;
            end
            default: if (p & RL) m_mode = 0;
        endcase
        m_chg = (m_zone() != z0) ? 1 : 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_mdc"}, 32'(mdc), m_col);
        check({tag, "_mdl"}, 32'(mdl), m_row);
        check({tag, "_sel"}, 32'(dmx_sel), m_zone());
        check({tag, "_chg"}, 32'(sel_changed), m_chg);
        check({tag, "_lock"}, 32'(locked), (m_mode == 2) ? 1 : 0);
    endtask

    // Inputs change 1 time unit after a rising edge and are sampled at the next one.
    task automatic step(input logic [7:0] p, input string tag);
        {release_lock, confirm, scan_stop, scan_start, mv_right, mv_left, mv_down, mv_up} = p;
        @(posedge clk); #1;
        {release_lock, confirm, scan_stop, scan_start, mv_right, mv_left, mv_down, mv_up} = '0;
        m_update(p);
        check_all(tag);
    endtask

    // Asynchronous reset pulse between clock edges.
    task automatic async_reset(input string tag);
        #2 reset = 1'b1;
        #1;
        m_reset();
        check_all(tag);
        #1 reset = 1'b0;
    endtask

    initial begin
        logic [7:0] p;
        m_reset();
        @(posedge clk); #1;
        check_all("rst");
        reset = 1'b0;

        step(R, "r1");
        step(R, "r2");
        check("tp_mdc2", 32'(mdc), 2);
        check("tp_sel1", 32'(dmx_sel), 1);
        check("tp_chg", 32'(sel_changed), 1);
        for (int i = 0; i < 5; i++) step(R, "r_more");
        step(R, "edge_r");
`ifdef SELETOR_WRAP_EN
        check("edge_mdc", 32'(mdc), 0);
`else
        check("edge_mdc", 32'(mdc), 7);
`endif
        for (int i = 0; i < 3; i++) step(L, "l_back");
        for (int i = 0; i < 4; i++) step(DN, "d_down");
        step(U | DN | L, "ud_l");
        check("tp_ud_mdc", 32'(mdc), 3);
        check("tp_ud_mdl", 32'(mdl), 4);
        check("tp_ud_sel", 32'(dmx_sel), 9);

        step(ST, "snap");
        step(SP, "stop");
        async_reset("rst_move");

        step(ST, "scan_in");
        for (int i = 0; i < 4 * ZONES; i++) begin
            step('0, "scan");
            if (i == 3) check("scan_z1", 32'(dmx_sel), 1);
        end
        check("scan_wrap", 32'(dmx_sel), 0);
        for (int i = 0; i < 200 && m_zone() != 6; i++) step('0, "to_z6");
        step(CF | SP, "cf_lock");
        check("lock_sel", 32'(dmx_sel), 6);
        check("lock_flag", 32'(locked), 1);
        step(R | DN, "lk_mv");
        step(ST, "lk_st");
        step(SP, "lk_sp");
        step(CF, "lk_cf");
        step(RL, "rel");
        check("rel_mdc", 32'(mdc), 4);
        check("rel_mdl", 32'(mdl), 2);
        step(RL | R, "mv_after");

        step(ST, "scan2");
        step('0, "scan2_w");
        step(CF, "lock2");
        async_reset("rst_lock");
        step(DN, "post_rst");
        check("post_mdl", 32'(mdl), 1);

        for (int i = 0; i < 600; i++) begin
            p = '0;
            p[0] = ($urandom_range(0, 2) == 0);
            p[1] = ($urandom_range(0, 2) == 0);
            p[2] = ($urandom_range(0, 2) == 0);
            p[3] = ($urandom_range(0, 2) == 0);
            p[4] = ($urandom_range(0, 15) == 0);
            p[5] = ($urandom_range(0, 23) == 0);
            p[6] = ($urandom_range(0, 19) == 0);
            p[7] = ($urandom_range(0, 5) == 0);
            step(p, "rand");
            if (i == 300) async_reset("rand_rst");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seletor_zona_matriz.md
# seletor_zona_matriz

Parametrised cursor-to-zone selector for the LED-matrix display path. Holds a registered column/row cursor driven by single-cycle move pulses or by an automatic scan, and maps the cursor onto a power-of-two grid of zones. The resulting zone index drives the downstream demultiplexer select. A lock mode freezes the selection while the rest of the display logic consumes it.

## Interface
- COL_W, 3: column cursor width; matrix has 2**COL_W columns.
- ROW_W, 3: row cursor width; matrix has 2**ROW_W rows.
- ZW_LOG2, 1: log2 of zone width in columns; 0 ≤ ZW_LOG2 ≤ COL_W.
- ZH_LOG2, 1: log2 of zone height in rows; 0 ≤ ZH_LOG2 ≤ ROW_W.
- DWELL, 4: cycles spent on each zone in SCAN; DWELL ≥ 1.
- Derived: SEL_W = (COL_W−ZW_LOG2)+(ROW_W−ZH_LOG2). Defaults give SEL_W = 4, i.e. 16 zones.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- mv_up, mv_down, mv_left, mv_right  in  1 each  single-cycle move pulses.
- scan_start  in  1  pulse: enter SCAN.
- scan_stop  in  1  pulse: leave SCAN for MOVE.
- confirm  in  1  pulse: lock current zone.
- release  in  1  pulse: unlock, return to MOVE.
- mdc  out  COL_W  cursor column.
- mdl  out  ROW_W  cursor row.
- dmx_sel  out  SEL_W  zone index = {mdl>>ZH_LOG2, mdc>>ZW_LOG2}, row part in the MSBs.
- sel_changed  out  1  one-cycle pulse when dmx_sel changes.
- locked  out  1  high in LOCKED.

## Operation
- FSM states: MOVE, SCAN, LOCKED. Reset state is MOVE.
- MOVE transitions:
  - confirm → LOCKED.
  - scan_start → SCAN; dwell counter cleared.
  - Moves apply only in MOVE.
- Move rules:
  - mv_up decrements mdl; mv_down increments mdl; mv_left decrements mdc; mv_right increments mdc.
  - up+down in the same cycle: no vertical move. left+right in the same cycle: no horizontal move.
  - Vertical and horizontal moves in the same cycle both apply.
- Edge behaviour is set by the macro (see Configuration).
- SCAN:
  - On entry, cursor snaps to zone origin: mdc = zx<<ZW_LOG2, mdl = zy<<ZH_LOG2, taken from the current zone.
  - Dwell counter counts 0..DWELL−1. At DWELL−1 it advances zx; on zx overflow zx = 0 and zy advances.
  - From the last zone, SCAN always wraps to zone 0, independent of the macro.
- SCAN exits:
  - confirm → LOCKED at the current zone.
  - scan_stop → MOVE; cursor kept.
  - confirm and scan_stop together: confirm wins.
- LOCKED:
  - Moves, scan_start and scan_stop are ignored.
  - release → MOVE. confirm in LOCKED has no effect.
- MOVE priority: confirm > scan_start > moves. A confirm uses the pre-move cursor, and moves in that cycle are dropped.
- Move pulses are not queued. A pulse arriving in any non-MOVE state is lost.

## Timing
- Reset values: mdc = 0, mdl = 0, dmx_sel = 0, sel_changed = 0, locked = 0; FSM in MOVE; dwell counter 0.
- Reset is asynchronous and may assert mid-scan or while locked. It applies immediately with no pending state.
- Move pulse at edge N → mdc/mdl/dmx_sel updated after edge N (1-cycle latency).
- dmx_sel is registered and always consistent with mdc/mdl in the same cycle.
- sel_changed is high for exactly the cycle after the zone index changes. It stays low for cursor moves that remain inside one zone.
- locked rises the cycle after the confirm edge and falls the cycle after the release edge.
- SCAN: with DWELL = D, each zone is held for exactly D cycles. The first zone after entry is also held for D cycles.

## Configuration
- SELETOR_WRAP_EN defined: moves wrap at the edges, e.g. mdc = 2**COL_W−1 + right → 0, and mdl = 0 + up → 2**ROW_W−1.
- SELETOR_WRAP_EN undefined: moves saturate at the edges, so the cursor holds at 0 or at max. A saturated move produces no sel_changed.

## Test plan
- Reset, then mv_right ×2 with defaults → mdc = 2, mdl = 0, dmx_sel = 1; sel_changed pulses once (on the 2nd move).
- mdc = 7, mv_right → with WRAP_EN: mdc = 0, dmx_sel zone-x = 0, sel_changed pulses. Without WRAP_EN: mdc = 7, no pulse.
- mv_up and mv_down together with mv_left at mdc = 4, mdl = 4 → mdc = 3, mdl = 4, dmx_sel = 9.
- scan_start with DWELL = 4 → dmx_sel steps 0,1,2,…,15,0 every 4 cycles.
- Mid-scan at zone 6, confirm → locked = 1, dmx_sel stays 6. Moves are ignored. release → MOVE at mdc = 4, mdl = 2.
- Assert reset while locked in SCAN-derived state → all outputs 0, FSM in MOVE. A post-reset mv_down gives mdl = 1.
